// File: rtl/cas_lock_pkg.sv
// rtl/cas_lock_pkg.sv - shared types, defaults and checksum fold for the CAS-Lock key loader
//
// Purpose : loader FSM state encoding, default key/checksum widths and the
//           XOR-fold checksum used to verify a received key.
// Contents: load_state_t, CAS_KEY_W, CAS_CHK_W, chk_fold()

package cas_lock_pkg;

  localparam int CAS_KEY_W = 64;
  localparam int CAS_CHK_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    CHKSUM = 2'd2,
    CHECK  = 2'd3
  } load_state_t;

  // XOR of all CHK_W-bit chunks of the key, chunk 0 at the LSB end.
  function automatic logic [CAS_CHK_W-1:0] chk_fold(input logic [CAS_KEY_W-1:0] key);
    logic [CAS_CHK_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < CAS_KEY_W / CAS_CHK_W; i++) begin
      acc = acc ^ key[i*CAS_CHK_W +: CAS_CHK_W];
    end
    return acc;
  endfunction

endpackage

// File: rtl/cas_key_shifter.sv
// rtl/cas_key_shifter.sv - shadow key/checksum shift registers with accepted-beat counter
//
// Purpose : collects the serial key stream, then the checksum, LSB first.
// Ports   : clk, rst      - clock, synchronous active-high reset
//           clear         - zero shadow, checksum and counter (start/restart of a load)
//           shift_en      - accept bit_in this cycle
//           bit_in        - serial data bit
//           shadow        - received key bits
//           chk           - received checksum bits
//           count         - number of accepted beats, saturating at KEY_W+CHK_W

module cas_key_shifter #(
  parameter int KEY_W = 64,
  parameter int CHK_W = 8,
  parameter int CNT_W = $clog2(KEY_W + CHK_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             bit_in,
  output logic [KEY_W-1:0] shadow,
  output logic [CHK_W-1:0] chk,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] KEY_BEATS = CNT_W'(KEY_W);
  localparam logic [CNT_W-1:0] ALL_BEATS = CNT_W'(KEY_W + CHK_W);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      shadow <= '0;
      chk    <= '0;
      count  <= '0;
    end else if (shift_en) begin
      // The counter selects the destination: first KEY_W beats build the
      // key, the remainder build the checksum. New bits enter at the MSB so
      // the first bit received lands at bit 0 once the field is full.
      if (count < KEY_BEATS) begin
        shadow <= {bit_in, shadow[KEY_W-1:1]};
      end else begin
        chk <= {bit_in, chk[CHK_W-1:1]};
      end
      if (count != ALL_BEATS) begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/cas_key_loader.sv
// rtl/cas_key_loader.sv - checksum-verified serial key loader driving the CAS-Lock keyinputs
//
// Purpose : receives KEY_W key bits then CHK_W checksum bits over a valid/ready
//           bit stream and commits the key only if the XOR-fold matches.
//           Until then key_o is all-zero (a wrong key for the locked netlist).
// Ports   : clk, rst      - clock, synchronous active-high reset
//           load_start    - begin or restart a load (ignored in CHECK)
//           sdi, sdi_valid, sdi_ready - serial bit stream handshake
//           key_o         - committed key, key_o[i] drives keyinput_i
//           key_valid     - key_o holds a verified key
//           load_busy     - load in progress (SHIFT, CHKSUM, CHECK)
//           load_err      - sticky: last load failed its checksum

module cas_key_loader
  import cas_lock_pkg::*;
#(
  parameter int KEY_W = CAS_KEY_W,
  parameter int CHK_W = CAS_CHK_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_start,
  input  logic             sdi,
  input  logic             sdi_valid,
  output logic             sdi_ready,
  output logic [KEY_W-1:0] key_o,
  output logic             key_valid,
  output logic             load_busy,
  output logic             load_err
);

  localparam int CNT_W = $clog2(KEY_W + CHK_W + 1);
  localparam logic [CNT_W-1:0] LAST_KEY_BEAT = CNT_W'(KEY_W - 1);
  localparam logic [CNT_W-1:0] LAST_CHK_BEAT = CNT_W'(KEY_W + CHK_W - 1);

  load_state_t      state;
  logic [KEY_W-1:0] shadow;
  logic [CHK_W-1:0] chk;
  logic [CNT_W-1:0] count;
  logic [CHK_W-1:0] fold;
  logic             in_stream;
  logic             clear;
  logic             accept;

  assign in_stream = (state == SHIFT) || (state == CHKSUM);
  assign sdi_ready = in_stream;
  assign load_busy = (state != IDLE);

  // A start/restart zeroes the shifter; a beat offered alongside a restart
  // is dropped so the new stream begins cleanly at beat 0.
  assign clear  = load_start && ((state == IDLE) || in_stream);
  assign accept = sdi_valid && sdi_ready && !load_start;

  cas_key_shifter #(
    .KEY_W (KEY_W),
    .CHK_W (CHK_W),
    .CNT_W (CNT_W)
  ) u_shifter (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .shift_en (accept),
    .bit_in   (sdi),
    .shadow   (shadow),
    .chk      (chk),
    .count    (count)
  );

  // Width-generic fold of the shadow key; matches chk_fold() at default widths.
  always_comb begin
    fold = '0;
    for (int i = 0; i < KEY_W / CHK_W; i++) begin
      fold = fold ^ shadow[i*CHK_W +: CHK_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      key_o     <= '0;
      key_valid <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_start) begin
            state    <= SHIFT;
            load_err <= 1'b0;
          end
        end
        SHIFT: begin
          if (load_start) begin
            state <= SHIFT;
          end else if (accept && (count == LAST_KEY_BEAT)) begin
            state <= CHKSUM;
          end
        end
        CHKSUM: begin
          if (load_start) begin
            state <= SHIFT;
          end else if (accept && (count == LAST_CHK_BEAT)) begin
            state <= CHECK;
          end
        end
        CHECK: begin
          // Single decision cycle; load_start here is deliberately ignored.
          if (fold == chk) begin
            key_o     <= shadow;
            key_valid <= 1'b1;
            load_err  <= 1'b0;
          end else begin
            key_o     <= '0;
            key_valid <= 1'b0;
            load_err  <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cas_key_loader.sv
// tb/tb_cas_key_loader.sv - self-checking bench for cas_key_loader

module tb_cas_key_loader;
  import cas_lock_pkg::*;

  logic        clk;
  logic        rst;
  logic        load_start;
  logic        sdi;
  logic        sdi_valid;
  logic        sdi_ready;
  logic [63:0] key_o;
  logic        key_valid;
  logic        load_busy;
  logic        load_err;

  int n_pass;
  int n_total;
  logic        timeout_seen;
  logic [63:0] prev_key;
  logic        prev_valid;

  typedef struct {
    logic [63:0] key;
    logic [7:0]  chk;
    int          max_gap;
    logic        exp_valid;
    logic [63:0] exp_key;
    logic        exp_err;
  } vec_t;

  vec_t vecs[4];

  cas_key_loader #(.KEY_W(64), .CHK_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .sdi        (sdi),
    .sdi_valid  (sdi_valid),
    .sdi_ready  (sdi_ready),
    .key_o      (key_o),
    .key_valid  (key_valid),
    .load_busy  (load_busy),
    .load_err   (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // load_start pulse with a beat offered in the same cycle (must be discarded).
  task automatic pulse_start();
    load_start = 1'b1;
    sdi_valid  = 1'b1;
    sdi        = 1'b1;
    step();
    load_start = 1'b0;
    sdi_valid  = 1'b0;
  endtask

  task automatic send_bit(input logic b, input int gap);
    int n;
    sdi_valid = 1'b0;
    for (int g = 0; g < gap; g++) step();
    sdi       = b;
    sdi_valid = 1'b1;
    n = 0;
    while (!sdi_ready && n < 8) begin
      step();
      n++;
    end
    if (!sdi_ready) timeout_seen = 1'b1;
    step();
    sdi_valid = 1'b0;
  endtask

  // Full load; returns at the CHECK cycle (one cycle after the last beat's edge).
  task automatic send_load(input logic [63:0] key, input logic [7:0] chk,
                           input int max_gap, output logic hold_ok);
    logic b;
    pulse_start();
    hold_ok = 1'b1;
    for (int i = 0; i < 72; i++) begin
      b = (i < 64) ? key[i] : chk[i-64];
      send_bit(b, (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
      if (key_o !== prev_key || key_valid !== prev_valid || load_busy !== 1'b1) hold_ok = 1'b0;
    end
  endtask

  task automatic apply_and_check(input string tag, input logic [63:0] key, input logic [7:0] chk,
                                 input int max_gap, input logic exp_valid,
                                 input logic [63:0] exp_key, input logic exp_err);
    logic hold_ok;
    timeout_seen = 1'b0;
    send_load(key, chk, max_gap, hold_ok);
    check({tag, "_beat_timeout"}, 64'(timeout_seen), 64'd0);
    check({tag, "_hold_during_load"}, 64'(hold_ok), 64'd1);
    check({tag, "_valid_before_commit"}, 64'(key_valid), 64'(prev_valid));
    check({tag, "_busy_in_check"}, 64'(load_busy), 64'd1);
    step();
    check({tag, "_key"}, key_o, exp_key);
    check({tag, "_valid"}, 64'(key_valid), 64'(exp_valid));
    check({tag, "_err"}, 64'(load_err), 64'(exp_err));
    check({tag, "_busy_after"}, 64'(load_busy), 64'd0);
    prev_key   = exp_key;
    prev_valid = exp_valid;
  endtask

  initial begin
    logic [63:0] rkey;
    logic        dummy;
    n_pass = 0;
    n_total = 0;
    timeout_seen = 1'b0;
    rst = 1'b1;
    load_start = 1'b0;
    sdi = 1'b0;
    sdi_valid = 1'b0;
    prev_key = 64'd0;
    prev_valid = 1'b0;

    vecs[0] = '{64'h0123_4567_89AB_CDEF, 8'h00, 0, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b0};
    vecs[1] = '{64'h0123_4567_89AB_CDEF, 8'h01, 0, 1'b0, 64'h0,                   1'b1};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FF00, 8'hFF, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FF00, 1'b0};
    vecs[3] = '{64'h0123_4567_89AB_CDEF, 8'h00, 5, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b0};

    step();
    step();
    rst = 1'b0;
    check("rst_key", key_o, 64'd0);
    check("rst_valid", 64'(key_valid), 64'd0);
    check("rst_err", 64'(load_err), 64'd0);
    check("rst_ready", 64'(sdi_ready), 64'd0);
    check("rst_busy", 64'(load_busy), 64'd0);

    for (int v = 0; v < 4; v++) begin
      apply_and_check($sformatf("vec%0d", v), vecs[v].key, vecs[v].chk, vecs[v].max_gap,
                      vecs[v].exp_valid, vecs[v].exp_key, vecs[v].exp_err);
    end

    // Restart after 30 beats; first stream must leave no trace.
    pulse_start();
    for (int i = 0; i < 30; i++) send_bit(1'b1 ^ i[0], 0);
    check("restart_old_key_held", key_o, 64'h0123_4567_89AB_CDEF);
    apply_and_check("restart", 64'hFFFF_FFFF_FFFF_FF00, 8'hFF, 0,
                    1'b1, 64'hFFFF_FFFF_FFFF_FF00, 1'b0);

    // load_start on the CHECK cycle is ignored.
    send_load(64'h0123_4567_89AB_CDEF, 8'h00, 0, dummy);
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    check("chkign_key", key_o, 64'h0123_4567_89AB_CDEF);
    check("chkign_valid", 64'(key_valid), 64'd1);
    check("chkign_busy", 64'(load_busy), 64'd0);
    step();
    check("chkign_still_idle", 64'(load_busy), 64'd0);
    prev_key = 64'h0123_4567_89AB_CDEF;
    prev_valid = 1'b1;

    // Reset during CHKSUM clears committed key and aborts the load.
    pulse_start();
    for (int i = 0; i < 67; i++) send_bit(1'b0, 0);
    check("midrst_in_load", 64'(load_busy), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_key", key_o, 64'd0);
    check("midrst_valid", 64'(key_valid), 64'd0);
    check("midrst_busy", 64'(load_busy), 64'd0);
    check("midrst_ready", 64'(sdi_ready), 64'd0);
    sdi_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      sdi = i[0];
      step();
    end
    sdi_valid = 1'b0;
    check("midrst_ignore_busy", 64'(load_busy), 64'd0);
    check("midrst_ignore_valid", 64'(key_valid), 64'd0);
    prev_key = 64'd0;
    prev_valid = 1'b0;

    // Random key with reference checksum from the package fold.
    rkey = {$urandom(), $urandom()};
    apply_and_check("rand", rkey, chk_fold(rkey), 2, 1'b1, rkey, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
